// File: rtl/pipeline_pkg.sv
// Shared types for the decode/issue/writeback pipeline.
//   reg_idx_t  : architectural register index (x0..x31)
//   issue_op_t : fields carried by the issue register
//   REG_X0     : hard-wired zero register, never tracked
package pipeline_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     we;
  } issue_op_t;

  localparam reg_idx_t REG_X0 = 5'd0;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters for the issue scoreboard.
// Ports:
//   i_clk, i_rst_n       clock, async active-low reset
//   i_inc_en, i_inc_idx  one increment request (handoff of a writing op)
//   i_dec_en, i_dec_idx  one decrement request (writeback retire)
//   o_pend               flattened counters, entry i at [i*PEND_W +: PEND_W]
//   o_zero, o_sat        per-register "count is 0" / "count is max"
//   o_dec_err            decrement of a zero count with no offsetting increment
// Entry 0 (x0) is never modified and always reads 0.
module sb_counter_bank
  import pipeline_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_inc_en,
  input  logic [4:0]                i_inc_idx,
  input  logic                      i_dec_en,
  input  logic [4:0]                i_dec_idx,
  output logic [NREGS*PEND_W-1:0]   o_pend,
  output logic [NREGS-1:0]          o_zero,
  output logic [NREGS-1:0]          o_sat,
  output logic                      o_dec_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] r_pend [NREGS];
  logic [NREGS-1:0]  w_inc;
  logic [NREGS-1:0]  w_dec;
  logic [NREGS-1:0]  w_zero;
  logic [NREGS-1:0]  w_sat;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NREGS; i++) begin
      w_inc[i] = i_inc_en && (int'(i_inc_idx) == i);
      w_dec[i] = i_dec_en && (int'(i_dec_idx) == i);
    end
  end

  // Simultaneous inc and dec of one entry cancel. The saturate/zero guards
  // keep the counter in range even if a caller misbehaves.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_pend[i] != PEND_MAX))
          r_pend[i] <= r_pend[i] + PEND_W'(1);
        else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0))
          r_pend[i] <= r_pend[i] - PEND_W'(1);
      end
    end
  end

  always_comb begin
    o_pend = '0;
    w_zero = '0;
    w_sat  = '0;
    for (int i = 0; i < NREGS; i++) begin
      o_pend[i*PEND_W +: PEND_W] = r_pend[i];
      w_zero[i] = (r_pend[i] == '0);
      w_sat[i]  = (r_pend[i] == PEND_MAX);
    end
  end

  assign o_zero    = w_zero;
  assign o_sat     = w_sat;
  assign o_dec_err = i_dec_en && (i_dec_idx != REG_X0) && w_zero[i_dec_idx] &&
                     !(i_inc_en && (i_inc_idx == i_dec_idx));

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and single-entry issue register between decode and
// execute. Stalls decode on RAW/WAW hazards, backpressure and flush.
// Ports:
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_dec_*                               op offered by decode
//   o_dec_stalled                         decode must hold its op (comb)
//   o_iss_valid/i_iss_ready, o_iss_*      issue register and handshake
//   i_wb_valid, i_wb_rd                   writeback retire of one register
//   i_flush                               squash the op in the issue register
//   o_busy                                any pending counter non-zero
//   o_sb_err                              sticky retire-underflow flag
// Build option: define SCOREBOARD_BYPASS_EN to let a source whose single
// pending write retires this cycle issue without waiting (writeback bypass).
module issue_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int PEND_W = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_dec_valid,
  input  logic [4:0] i_dec_rs1,
  input  logic [4:0] i_dec_rs2,
  input  logic [4:0] i_dec_rd,
  input  logic       i_dec_use_rs1,
  input  logic       i_dec_use_rs2,
  input  logic       i_dec_we,
  output logic       o_dec_stalled,
  output logic       o_iss_valid,
  input  logic       i_iss_ready,
  output logic [4:0] o_iss_rs1,
  output logic [4:0] o_iss_rs2,
  output logic [4:0] o_iss_rd,
  output logic       o_iss_we,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_rd,
  input  logic       i_flush,
  output logic       o_busy,
  output logic       o_sb_err
);

  logic                    r_iss_valid;
  issue_op_t               r_iss;
  logic                    r_sb_err;

  logic [NREGS*PEND_W-1:0] w_pend;
  logic [NREGS-1:0]        w_zero;
  logic [NREGS-1:0]        w_sat;
  logic                    w_dec_err;
  logic                    w_handoff;
  logic                    w_inc_en;
  logic                    w_retire;
  logic                    w_iss_hit1, w_iss_hit2;
  logic                    w_byp1, w_byp2;
  logic                    w_raw1, w_raw2;
  logic                    w_waw;
  logic                    w_accept;

  // A handoff increments even when flush squashes the register that cycle:
  // the op has already left for execute.
  assign w_handoff = r_iss_valid && i_iss_ready;
  assign w_inc_en  = w_handoff && r_iss.we && (r_iss.rd != REG_X0);
  assign w_retire  = i_wb_valid && (i_wb_rd != REG_X0);

  sb_counter_bank #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc_en  (w_inc_en),
    .i_inc_idx (r_iss.rd),
    .i_dec_en  (w_retire),
    .i_dec_idx (i_wb_rd),
    .o_pend    (w_pend),
    .o_zero    (w_zero),
    .o_sat     (w_sat),
    .o_dec_err (w_dec_err)
  );

  // The op sitting in the issue register has not been counted yet, so it is
  // checked separately as a RAW source.
  assign w_iss_hit1 = r_iss_valid && r_iss.we && (r_iss.rd == i_dec_rs1);
  assign w_iss_hit2 = r_iss_valid && r_iss.we && (r_iss.rd == i_dec_rs2);

`ifdef SCOREBOARD_BYPASS_EN
  assign w_byp1 = (w_pend[int'(i_dec_rs1)*PEND_W +: PEND_W] == PEND_W'(1)) &&
                  i_wb_valid && (i_wb_rd == i_dec_rs1);
  assign w_byp2 = (w_pend[int'(i_dec_rs2)*PEND_W +: PEND_W] == PEND_W'(1)) &&
                  i_wb_valid && (i_wb_rd == i_dec_rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_raw1 = i_dec_use_rs1 && (i_dec_rs1 != REG_X0) &&
                  ((!w_zero[i_dec_rs1] && !w_byp1) || w_iss_hit1);
  assign w_raw2 = i_dec_use_rs2 && (i_dec_rs2 != REG_X0) &&
                  ((!w_zero[i_dec_rs2] && !w_byp2) || w_iss_hit2);
  assign w_waw  = i_dec_we && (i_dec_rd != REG_X0) && w_sat[i_dec_rd];

  assign w_accept = i_dec_valid && !(w_raw1 || w_raw2 || w_waw) &&
                    (!r_iss_valid || i_iss_ready) && !i_flush;
  assign o_dec_stalled = i_dec_valid && !w_accept;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss       <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_iss_valid <= 1'b1;
        r_iss       <= '{rs1: i_dec_rs1, rs2: i_dec_rs2, rd: i_dec_rd, we: i_dec_we};
      end else if (w_handoff || i_flush) begin
        r_iss_valid <= 1'b0;
      end
      if (w_dec_err) r_sb_err <= 1'b1;
    end
  end

  assign o_iss_valid = r_iss_valid;
  assign o_iss_rs1   = r_iss.rs1;
  assign o_iss_rs2   = r_iss.rs2;
  assign o_iss_rd    = r_iss.rd;
  assign o_iss_we    = r_iss.we;
  assign o_busy      = |w_pend;
  assign o_sb_err    = r_sb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic       dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0, dec_we = 1'b0;
  logic       dec_stalled;
  logic       iss_valid;
  logic       iss_ready = 1'b1;
  logic [4:0] iss_rs1, iss_rs2, iss_rd;
  logic       iss_we;
  logic       wb_valid = 1'b0;
  logic [4:0] wb_rd = '0;
  logic       flush = 1'b0;
  logic       busy, sb_err;

  int checks = 0;
  int errors = 0;

  issue_op_t exp_q[$];
  int        model_pend[32];
  logic      model_err = 1'b0;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dec_valid(dec_valid), .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
    .i_dec_use_rs1(dec_use_rs1), .i_dec_use_rs2(dec_use_rs2), .i_dec_we(dec_we),
    .o_dec_stalled(dec_stalled), .o_iss_valid(iss_valid), .i_iss_ready(iss_ready),
    .o_iss_rs1(iss_rs1), .o_iss_rs2(iss_rs2), .o_iss_rd(iss_rd), .o_iss_we(iss_we),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
    .o_busy(busy), .o_sb_err(sb_err)
  );

  // Scoreboard monitor: inputs change on negedge, so negedge+2 shows the
  // state after the last posedge and the inputs of the coming posedge.
  always begin : monitor
    logic      mb;
    int        inc_r, dec_r;
    issue_op_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_pend[i] = 0;
      model_err = 1'b0;
    end else begin
      mb = 1'b0;
      for (int i = 0; i < 32; i++) if (model_pend[i] != 0) mb = 1'b1;
      checks++;
      if (busy !== mb) begin errors++; $display("FAIL mon_busy: got %b want %b t=%0t", busy, mb, $time); end
      checks++;
      if (sb_err !== model_err) begin errors++; $display("FAIL mon_sb_err: got %b want %b t=%0t", sb_err, model_err, $time); end
      inc_r = -1;
      dec_r = -1;
      if (iss_valid && iss_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected_handoff: got rd=%0d want no handoff t=%0t", iss_rd, $time);
        end else begin
          e = exp_q.pop_front();
          if ({iss_rs1, iss_rs2, iss_rd, iss_we} !== e) begin
            errors++;
            $display("FAIL mon_issue_op: got rs1=%0d rs2=%0d rd=%0d we=%b want rs1=%0d rs2=%0d rd=%0d we=%b t=%0t",
                     iss_rs1, iss_rs2, iss_rd, iss_we, e.rs1, e.rs2, e.rd, e.we, $time);
          end
        end
        if (iss_we && iss_rd != 0) inc_r = int'(iss_rd);
      end
      if (wb_valid && wb_rd != 0) dec_r = int'(wb_rd);
      if (!(inc_r >= 0 && inc_r == dec_r)) begin
        if (inc_r >= 0 && model_pend[inc_r] < 3) model_pend[inc_r]++;
        if (dec_r >= 0) begin
          if (model_pend[dec_r] == 0) model_err = 1'b1;
          else model_pend[dec_r]--;
        end
      end
    end
  end

  task automatic drive_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic we);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_we = we;
  endtask

  task automatic push_cur();
    exp_q.push_back('{rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd, we: dec_we});
  endtask

  task automatic idle_dec();
    dec_valid = 1'b0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_we = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd);
    @(negedge clk); wb_valid = 1'b1; wb_rd = rd;
    @(negedge clk); wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive_op(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL rst_stalled: got %b want 0", dec_stalled); end
    repeat (2) @(negedge clk);
    idle_dec();
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL rst_iss_valid: got %b want 0", iss_valid); end
    checks++; if ({iss_rs1, iss_rs2, iss_rd, iss_we} !== 16'h0) begin errors++; $display("FAIL rst_iss_fields: got %h want 0", {iss_rs1, iss_rs2, iss_rd, iss_we}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err: got %b want 0", sb_err); end
  endtask

  task automatic test_raw();
    iss_ready = 1'b1;
    @(negedge clk); drive_op(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL raw_first_accept: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); drive_op(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL raw_iss_reg: got %b want 1", dec_stalled); end
    @(negedge clk); #1;
    checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL raw_pend: got %b want 1", dec_stalled); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", busy); end
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd5; #1;
`ifdef SCOREBOARD_BYPASS_EN
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL raw_bypass: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); wb_valid = 1'b0; idle_dec();
`else
    checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL raw_retire_cycle: got %b want 1", dec_stalled); end
    @(negedge clk); wb_valid = 1'b0; #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL raw_after_retire: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec();
`endif
    #1;
    checks++; if (iss_valid !== 1'b1 || iss_rd !== 5'd6) begin errors++; $display("FAIL raw_dep_issued: got valid=%b rd=%0d want valid=1 rd=6", iss_valid, iss_rd); end
    retire(5'd6); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clk); iss_ready = 1'b0; drive_op(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL bp_first_accept: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); drive_op(5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL bp_stall_%0d: got %b want 1", k, dec_stalled); end
      checks++; if (iss_valid !== 1'b1 || iss_rd !== 5'd10) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b rd=%0d want valid=1 rd=10", k, iss_valid, iss_rd); end
      @(negedge clk);
    end
    iss_ready = 1'b1; #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec(); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_pend10: got %b want 1", busy); end
    retire(5'd10);
    retire(5'd11); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_waw();
    iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive_op(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1); #1;
      checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL waw_write_%0d: got %b want 0", k, dec_stalled); end
      push_cur();
      @(negedge clk); idle_dec();
    end
    @(negedge clk); drive_op(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL waw_sat: got %b want 1", dec_stalled); end
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd7; #1;
    checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL waw_retire_cycle: got %b want 1", dec_stalled); end
    @(negedge clk); wb_valid = 1'b0; #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL waw_after_retire: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec(); #1;
    checks++; if (iss_valid !== 1'b1 || iss_rd !== 5'd7) begin errors++; $display("FAIL waw_fourth_issued: got valid=%b rd=%0d want valid=1 rd=7", iss_valid, iss_rd); end
    repeat (3) retire(5'd7);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL waw_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_flush();
    @(negedge clk); iss_ready = 1'b0; drive_op(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL fl_accept: got %b want 0", dec_stalled); end
    @(negedge clk); #1;
    checks++; if (iss_valid !== 1'b1 || iss_rd !== 5'd9) begin errors++; $display("FAIL fl_loaded: got valid=%b rd=%0d want valid=1 rd=9", iss_valid, iss_rd); end
    flush = 1'b1; drive_op(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b1) begin errors++; $display("FAIL fl_stall: got %b want 1", dec_stalled); end
    @(negedge clk); flush = 1'b0; idle_dec(); #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL fl_squashed: got %b want 0", iss_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy: got %b want 0", busy); end
    drive_op(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL fl_pend9_zero: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec(); iss_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_err_x0();
    @(negedge clk); wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); wb_valid = 1'b0; #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", sb_err); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", sb_err); end
    @(negedge clk); drive_op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL x0_write_accept: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); drive_op(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL x0_read_no_hazard: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec(); wb_valid = 1'b1; wb_rd = 5'd0;
    @(negedge clk); wb_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk); drive_op(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1); push_cur();
    @(negedge clk); drive_op(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL mr_second_write: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec();
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy_before: got %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || iss_valid !== 1'b0) begin errors++; $display("FAIL mr_async: got busy=%b valid=%b want 0 0", busy, iss_valid); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL mr_iss_valid: got %b want 0", iss_valid); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL mr_sb_err: got %b want 0", sb_err); end
    drive_op(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (dec_stalled !== 1'b0) begin errors++; $display("FAIL mr_no_stale_pend: got %b want 0", dec_stalled); end
    push_cur();
    @(negedge clk); idle_dec();
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raw();
    test_backpressure();
    test_waw();
    test_flush();
    test_err_x0();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drained: got %0d pending want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
